// File: rtl/l2_sio_resp_checker.sv
// l2_sio_resp_checker: per-bank L2->SIO response protocol checker.
// Each bank runs an IDLE/DATA tracker, reduces its per-cycle findings to one
// event, parks it in a one-entry pending slot, and a round-robin arbiter moves
// pending events into a shared event FIFO drained by a valid/ready handshake.
module l2_sio_resp_checker #(
    parameter int unsigned NUM_BANKS  = 8,
    parameter int unsigned DW         = 32,
    parameter int unsigned PAY_BEATS  = 16,
    parameter int unsigned HDR_RD_BIT = 31,
    parameter int unsigned EVT_DEPTH  = 4,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                    iol2clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_BANKS-1:0]    ctag_vld,
    input  logic [NUM_BANKS*DW-1:0] data,
    input  logic [2*NUM_BANKS-1:0]  parity,
    input  logic [NUM_BANKS-1:0]    ue_err,
    output logic                    evt_vld,
    input  logic                    evt_rdy,
    output logic [BW-1:0]           evt_bank,
    output logic [1:0]              evt_code,
    output logic [DW-1:0]           evt_data,
    output logic                    evt_ovf,
    input  logic [BW-1:0]           cnt_sel,
    output logic [CNT_W-1:0]        cnt_val,
    output logic [NUM_BANKS-1:0]    busy
);

    localparam int unsigned HW     = DW / 2;
    localparam int unsigned BEAT_W = (PAY_BEATS > 1) ? $clog2(PAY_BEATS) : 1;
    localparam int unsigned PW     = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
    localparam int unsigned OCC_W  = $clog2(EVT_DEPTH + 1);

    localparam logic [1:0] EC_DONE = 2'd0;
    localparam logic [1:0] EC_PAR  = 2'd1;
    localparam logic [1:0] EC_UE   = 2'd2;
    localparam logic [1:0] EC_OVL  = 2'd3;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PAY_BEATS - 1);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(EVT_DEPTH);
    localparam logic [PW-1:0]     PTR_LAST  = PW'(EVT_DEPTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_e;

    // Per-bank tracker, counter and pending slot state
    state_e             state_q     [NUM_BANKS];
    state_e             state_d     [NUM_BANKS];
    logic [BEAT_W-1:0]  beat_q      [NUM_BANKS];
    logic [BEAT_W-1:0]  beat_d      [NUM_BANKS];
    logic [CNT_W-1:0]   cnt_q       [NUM_BANKS];
    logic [CNT_W-1:0]   cnt_d       [NUM_BANKS];
    logic [NUM_BANKS-1:0] pend_vld_q;
    logic [NUM_BANKS-1:0] pend_vld_d;
    logic [1:0]         pend_code_q [NUM_BANKS];
    logic [1:0]         pend_code_d [NUM_BANKS];
    logic [DW-1:0]      pend_data_q [NUM_BANKS];
    logic [DW-1:0]      pend_data_d [NUM_BANKS];

    // Arbiter and event FIFO state
    logic [BW-1:0]      ptr_q, ptr_d;
    logic [BW-1:0]      fifo_bank_q [EVT_DEPTH];
    logic [BW-1:0]      fifo_bank_d [EVT_DEPTH];
    logic [1:0]         fifo_code_q [EVT_DEPTH];
    logic [1:0]         fifo_code_d [EVT_DEPTH];
    logic [DW-1:0]      fifo_data_q [EVT_DEPTH];
    logic [DW-1:0]      fifo_data_d [EVT_DEPTH];
    logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               ovf_q, ovf_d;

    // Combinational scratch
    logic               pop, push, fifo_full, grant_vld;
    logic [BW-1:0]      grant_idx, cand;
    logic [DW-1:0]      bdata;
    logic               par_bad, is_hdr, is_pay, beat_act;
    logic               ev_ovl, ev_par, ev_ue, ev_done;
    logic [1:0]         ev_code;

    // Next-state: arbitration/FIFO first, then bank trackers refill pending slots
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cnt_d       = cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_code_d = pend_code_q;
        pend_data_d = pend_data_q;
        ptr_d       = ptr_q;
        fifo_bank_d = fifo_bank_q;
        fifo_code_d = fifo_code_q;
        fifo_data_d = fifo_data_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        occ_d       = occ_q;
        ovf_d       = ovf_q;
        grant_vld   = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        bdata       = '0;
        par_bad     = 1'b0;
        is_hdr      = 1'b0;
        is_pay      = 1'b0;
        beat_act    = 1'b0;
        ev_ovl      = 1'b0;
        ev_par      = 1'b0;
        ev_ue       = 1'b0;
        ev_done     = 1'b0;
        ev_code     = EC_DONE;

        pop       = (occ_q != '0) && evt_rdy;
        fifo_full = (occ_q == OCC_FULL);

        for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            cand = BW'((32'(ptr_q) + k) % NUM_BANKS);
            if (!grant_vld && pend_vld_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        push = grant_vld && !fifo_full;

        if (push) begin
            fifo_bank_d[wr_q]     = grant_idx;
            fifo_code_d[wr_q]     = pend_code_q[grant_idx];
            fifo_data_d[wr_q]     = pend_data_q[grant_idx];
            wr_d                  = (wr_q == PTR_LAST) ? '0 : wr_q + PW'(1);
            pend_vld_d[grant_idx] = 1'b0;
            ptr_d                 = BW'((32'(grant_idx) + 1) % NUM_BANKS);
        end
        if (pop) begin
            rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PW'(1);
        end
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);

        for (int b = 0; b < NUM_BANKS; b++) begin
            bdata    = data[b*DW +: DW];
            par_bad  = (parity[2*b] != ^bdata[HW-1:0]) ||
                       (parity[2*b+1] != ^bdata[DW-1:HW]);
            is_hdr   = enable && ctag_vld[b];
            is_pay   = enable && (state_q[b] == S_DATA);
            beat_act = is_hdr || is_pay;
            ev_ovl   = is_pay && ctag_vld[b];
            ev_par   = beat_act && par_bad;
            ev_ue    = beat_act && ue_err[b];
            ev_done  = 1'b0;

            if (!enable) begin
                state_d[b] = S_IDLE;
            end else if (is_hdr) begin
                // A header mid-payload abandons the old response and restarts
                if (bdata[HDR_RD_BIT]) begin
                    state_d[b] = S_DATA;
                    beat_d[b]  = '0;
                end else begin
                    state_d[b] = S_IDLE;
                    ev_done    = 1'b1;
                end
            end else if (is_pay) begin
                if (beat_q[b] == LAST_BEAT) begin
                    state_d[b] = S_IDLE;
                    ev_done    = 1'b1;
                end else begin
                    beat_d[b] = beat_q[b] + BEAT_W'(1);
                end
            end

            if (ev_done && (cnt_q[b] != {CNT_W{1'b1}})) begin
                cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end

            if (ev_ovl)      ev_code = EC_OVL;
            else if (ev_par) ev_code = EC_PAR;
            else if (ev_ue)  ev_code = EC_UE;
            else             ev_code = EC_DONE;

            // A slot leaving for the FIFO this cycle can be refilled at once
            if (ev_ovl || ev_par || ev_ue || ev_done) begin
                if (pend_vld_q[b] && !(push && (grant_idx == BW'(b)))) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_vld_d[b]  = 1'b1;
                    pend_code_d[b] = ev_code;
                    pend_data_d[b] = bdata;
                end
            end
        end
    end

    // Bank tracker, counter and pending slot registers
    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b]     <= S_IDLE;
                beat_q[b]      <= '0;
                cnt_q[b]       <= '0;
                pend_code_q[b] <= '0;
                pend_data_q[b] <= '0;
            end
            pend_vld_q <= '0;
            ptr_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_code_q <= pend_code_d;
            pend_data_q <= pend_data_d;
            ptr_q       <= ptr_d;
            ovf_q       <= ovf_d;
        end
    end

    // Event FIFO registers
    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < EVT_DEPTH; e++) begin
                fifo_bank_q[e] <= '0;
                fifo_code_q[e] <= '0;
                fifo_data_q[e] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            fifo_bank_q <= fifo_bank_d;
            fifo_code_q <= fifo_code_d;
            fifo_data_q <= fifo_data_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            occ_q       <= occ_d;
        end
    end

    // Outputs straight from flops: FIFO head, sticky overflow, bank busy
    always_comb begin
        evt_vld  = (occ_q != '0);
        evt_bank = fifo_bank_q[rd_q];
        evt_code = fifo_code_q[rd_q];
        evt_data = fifo_data_q[rd_q];
        evt_ovf  = ovf_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            busy[b] = (state_q[b] == S_DATA);
        end
    end

    // Counter read port; out-of-range selects read as zero
    always_comb begin
        cnt_val = '0;
        if (32'(cnt_sel) < NUM_BANKS) begin
            cnt_val = cnt_q[cnt_sel];
        end
    end

endmodule
